// File: rtl/systolic_feeder_3by3.sv
// systolic_feeder_3by3
//
// Feeds a 3x3 output-stationary systolic array from two parallel-loaded 3x3
// matrices. On start, A and B are captured. The array accumulators are then
// cleared. A rows and B columns are streamed over five diagonally skewed
// beats. The block waits for the array pipeline to drain and then pulses done.
//
// Every output comes from a register, so each output lags the FSM state that
// produced it by one cycle.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears all state and outputs
//   start          job request, only looked at while idle
//   mat_a          A[i][k] at bits [(i*3+k)*DATA_W +: DATA_W]
//   mat_b          B[k][j] at bits [(k*3+j)*DATA_W +: DATA_W]
//   a_out_0..2     row i of A, skewed by i beats, to array in_a_0..2
//   b_out_0..2     column j of B, skewed by j beats, to array in_b_0..2
//   feed_valid     high on the five feed beats
//   arr_clr        one-cycle accumulator clear for the array
//   busy           high whenever the FSM is not idle
//   done           one-cycle completion pulse

module systolic_feeder_3by3 #(
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [9*DATA_W-1:0]   mat_a,
  input  logic [9*DATA_W-1:0]   mat_b,
  output logic [DATA_W-1:0]     a_out_0,
  output logic [DATA_W-1:0]     a_out_1,
  output logic [DATA_W-1:0]     a_out_2,
  output logic [DATA_W-1:0]     b_out_0,
  output logic [DATA_W-1:0]     b_out_1,
  output logic [DATA_W-1:0]     b_out_2,
  output logic                  feed_valid,
  output logic                  arr_clr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 beatCnt_q, beatCnt_d;
  logic [3:0]                 drainCnt_q, drainCnt_d;
  logic [9*DATA_W-1:0]        matA_q, matA_d;
  logic [9*DATA_W-1:0]        matB_q, matB_d;
  logic [2:0][DATA_W-1:0]     aOut_q, aOut_d;
  logic [2:0][DATA_W-1:0]     bOut_q, bOut_d;
  logic                       feedValid_q, feedValid_d;
  logic                       arrClr_q, arrClr_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  // Next state, counters, matrix capture and the next output values.
  // The outputs are decoded from the current state and loaded into
  // registers. That produces the one-cycle lag between a state and what
  // the array sees.
  always_comb begin
    int k;
    state_d     = state_q;
    beatCnt_d   = beatCnt_q;
    drainCnt_d  = drainCnt_q;
    matA_d      = matA_q;
    matB_d      = matB_q;
    aOut_d      = '0;
    bOut_d      = '0;
    feedValid_d = 1'b0;
    arrClr_d    = 1'b0;
    done_d      = 1'b0;
    k           = 0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          matA_d  = mat_a;
          matB_d  = mat_b;
        end
      end
      CLEAR: begin
        arrClr_d  = 1'b1;
        beatCnt_d = 3'd0;
        state_d   = FEED;
      end
      FEED: begin
        feedValid_d = 1'b1;
        // On beat t, lane n carries element k = t - n of its row or column.
        // Lanes whose k falls outside 0..2 stay at zero. Those zeros fill the
        // skew triangles at both ends of the stream.
        for (int n = 0; n < 3; n++) begin
          k = int'(beatCnt_q) - n;
          if (k >= 0 && k <= 2) begin
            aOut_d[n] = matA_q[(n*3+k)*DATA_W +: DATA_W];
            bOut_d[n] = matB_q[(k*3+n)*DATA_W +: DATA_W];
          end
        end
        if (beatCnt_q == 3'd4) begin
          beatCnt_d  = 3'd0;
          drainCnt_d = 4'd0;
          state_d    = DRAIN;
        end else begin
          beatCnt_d = beatCnt_q + 3'd1;
        end
      end
      DRAIN: begin
        if (drainCnt_q == 4'(DRAIN_CYCLES - 1)) begin
          drainCnt_d = 4'd0;
          state_d    = DONE;
        end else begin
          drainCnt_d = drainCnt_q + 4'd1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy follows the state register directly, so it is registered from
    // the next state instead of lagging by a cycle.
    busy_d = (state_d != IDLE);
  end

  // State, counters, captured matrices and output registers.
  // Reset takes effect immediately, which also kills a partial stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      beatCnt_q   <= 3'd0;
      drainCnt_q  <= 4'd0;
      matA_q      <= '0;
      matB_q      <= '0;
      aOut_q      <= '0;
      bOut_q      <= '0;
      feedValid_q <= 1'b0;
      arrClr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beatCnt_q   <= beatCnt_d;
      drainCnt_q  <= drainCnt_d;
      matA_q      <= matA_d;
      matB_q      <= matB_d;
      aOut_q      <= aOut_d;
      bOut_q      <= bOut_d;
      feedValid_q <= feedValid_d;
      arrClr_q    <= arrClr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign a_out_0    = aOut_q[0];
  assign a_out_1    = aOut_q[1];
  assign a_out_2    = aOut_q[2];
  assign b_out_0    = bOut_q[0];
  assign b_out_1    = bOut_q[1];
  assign b_out_2    = bOut_q[2];
  assign feed_valid = feedValid_q;
  assign arr_clr    = arrClr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_systolic_feeder_3by3.sv
// tb_systolic_feeder_3by3
//
// Directed bench for systolic_feeder_3by3 with hand-computed expectations.
// A small 3x3 output-stationary array sits on the feeder outputs so that
// the product A*B can be checked at the done pulse.

module tb_systolic_feeder_3by3;

  localparam int DRAIN = 4;
  localparam int LAST  = 7 + DRAIN;

  logic        clk;
  logic        reset;
  logic        start;
  logic [71:0] mat_a;
  logic [71:0] mat_b;
  logic [7:0]  a_out_0, a_out_1, a_out_2;
  logic [7:0]  b_out_0, b_out_1, b_out_2;
  logic        feed_valid, arr_clr, busy, done;

  int vectors;
  int miscompares;

  // A = [[1,2,3],[4,5,6],[7,8,9]], B = [[8,7,6],[5,4,3],[2,1,0]], row-major
  int aMat[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int bMat[9] = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
  // A*B worked out by hand, row-major
  int cExp[9] = '{24, 18, 12, 69, 54, 39, 114, 90, 66};
  logic [71:0] matAVal, matBVal;
  // {a0,a1,a2,b0,b1,b2} for beats t=0..4
  logic [47:0] expStream[5];

  int arrCount, doneCount, busyLow, firstClr, secondClr, doneAfterReset;

  systolic_feeder_3by3 #(
    .DATA_W      (8),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mat_a      (mat_a),
    .mat_b      (mat_b),
    .a_out_0    (a_out_0),
    .a_out_1    (a_out_1),
    .a_out_2    (a_out_2),
    .b_out_0    (b_out_0),
    .b_out_1    (b_out_1),
    .b_out_2    (b_out_2),
    .feed_valid (feed_valid),
    .arr_clr    (arr_clr),
    .busy       (busy),
    .done       (done)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference output-stationary array. A values move right and B values
  // move down, one register per PE. Each PE accumulates a*b, and arr_clr
  // zeroes the accumulators.
  logic [7:0] aBus[3];
  logic [7:0] bBus[3];
  logic [7:0] aPipe[3][3];
  logic [7:0] bPipe[3][3];
  logic [7:0] aIn[3][3];
  logic [7:0] bIn[3][3];
  int         acc[3][3];

  assign aBus[0] = a_out_0;
  assign aBus[1] = a_out_1;
  assign aBus[2] = a_out_2;
  assign bBus[0] = b_out_0;
  assign bBus[1] = b_out_1;
  assign bBus[2] = b_out_2;

  // Operands seen by each PE: the array edge or the neighbour's register.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        aIn[i][j] = aBus[i];
        bIn[i][j] = bBus[j];
        if (j > 0) aIn[i][j] = aPipe[i][(j+2)%3];
        if (i > 0) bIn[i][j] = bPipe[(i+2)%3][j];
      end
    end
  end

  // PE registers and accumulators.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (reset) begin
          acc[i][j]   <= 0;
          aPipe[i][j] <= 8'd0;
          bPipe[i][j] <= 8'd0;
        end else begin
          acc[i][j]   <= arr_clr ? 0 : acc[i][j] + int'(aIn[i][j]) * int'(bIn[i][j]);
          aPipe[i][j] <= aIn[i][j];
          bPipe[i][j] <= bIn[i][j];
        end
      end
    end
  end

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Puts a matrix pair on the parallel inputs.
  task automatic applyStimulus(input logic [71:0] a, input logic [71:0] b);
    mat_a = a;
    mat_b = b;
  endtask

  function automatic logic [47:0] dataOuts();
    return {a_out_0, a_out_1, a_out_2, b_out_0, b_out_1, b_out_2};
  endfunction

  function automatic logic [51:0] allOuts();
    return {dataOuts(), feed_valid, arr_clr, busy, done};
  endfunction

  // Starts one job with the reference matrices. It then checks every cycle
  // up to two cycles past done: the stream, the flags, and the array
  // product at the done pulse.
  // corruptMats: overwrite the inputs one cycle after the start edge.
  // pokeStart: pulse start during FEED and during DRAIN.
  task automatic checkJob(input string name, input bit corruptMats, input bit pokeStart);
    logic [47:0] expData;
    logic [3:0]  expFlags;
    @(negedge clk);
    applyStimulus(matAVal, matBVal);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (corruptMats) applyStimulus({72{1'b1}}, {72{1'b1}});
    for (int n = 1; n <= LAST + 2; n++) begin
      @(posedge clk);
      @(negedge clk);
      expData  = (n >= 2 && n <= 6) ? expStream[n-2] : 48'd0;
      expFlags = {(n >= 2 && n <= 6), (n == 1), (n <= 6 + DRAIN), (n == LAST)};
      checkOutput($sformatf("%s e%0d data", name, n), 64'(dataOuts()), 64'(expData));
      checkOutput($sformatf("%s e%0d flags", name, n),
                  64'({feed_valid, arr_clr, busy, done}), 64'(expFlags));
      if (n == LAST) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            checkOutput($sformatf("%s C[%0d][%0d]", name, i, j),
                        64'(acc[i][j]), 64'(cExp[i*3+j]));
      end
      if (pokeStart) start = (n == 3 || n == 7);
    end
    start = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int idx = 0; idx < 9; idx++) begin
      matAVal[idx*8 +: 8] = 8'(aMat[idx]);
      matBVal[idx*8 +: 8] = 8'(bMat[idx]);
    end
    expStream[0] = {8'd1, 8'd0, 8'd0, 8'd8, 8'd0, 8'd0};
    expStream[1] = {8'd2, 8'd4, 8'd0, 8'd5, 8'd7, 8'd0};
    expStream[2] = {8'd3, 8'd5, 8'd7, 8'd2, 8'd4, 8'd6};
    expStream[3] = {8'd0, 8'd6, 8'd8, 8'd0, 8'd1, 8'd3};
    expStream[4] = {8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd0};

    // Scenario 1: reset while idle, then idle with no start.
    reset = 1'b1;
    start = 1'b0;
    applyStimulus(matAVal, matBVal);
    #3;
    checkOutput("reset outputs", 64'(allOuts()), 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset outputs held", 64'(allOuts()), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("idle c%0d", c), 64'(allOuts()), 64'd0);
    end

    // Scenario 2: the basic job.
    checkJob("basic", 1'b0, 1'b0);

    // Scenario 3: inputs change after capture.
    checkJob("capture", 1'b1, 1'b0);

    // Scenario 4a: start pulsed during FEED and DRAIN is ignored.
    checkJob("ignore", 1'b0, 1'b1);

    // Scenario 4b: start held high for 30 edges. Jobs repeat every 12 edges.
    @(negedge clk);
    applyStimulus(matAVal, matBVal);
    start     = 1'b1;
    arrCount  = 0;
    doneCount = 0;
    busyLow   = 0;
    firstClr  = -1;
    secondClr = -1;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (arr_clr) begin
        arrCount++;
        if (firstClr < 0) firstClr = e;
        else if (secondClr < 0) secondClr = e;
      end
      if (done) doneCount++;
      if (e >= 1 && e <= 12 && !busy) busyLow++;
      if (e == 29) start = 1'b0;
    end
    checkOutput("held arr_clr count", 64'(arrCount), 64'd3);
    checkOutput("held done count", 64'(doneCount), 64'd3);
    checkOutput("held first clr edge", 64'(firstClr), 64'd1);
    checkOutput("held job spacing", 64'(secondClr - firstClr), 64'd12);
    checkOutput("held idle gap", 64'(busyLow), 64'd1);

    // Scenario 5: reset at feed beat t=2 aborts the job at once.
    @(negedge clk);
    applyStimulus(matAVal, matBVal);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("abort beat2 data", 64'(dataOuts()), 64'(expStream[2]));
    #2 reset = 1'b1;
    #1 checkOutput("abort async outputs", 64'(allOuts()), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    doneAfterReset = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy || arr_clr) doneAfterReset++;
    end
    checkOutput("abort no resume", 64'(doneAfterReset), 64'd0);
    checkJob("after abort", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
